// File: rtl/data_mem_responder_if.sv
// Valid/ready bus between the Mem stage (master) and the data-memory responder (slave).
interface data_mem_responder_if;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, wr, addr, wdata, input ready, rvalid, rdata, err);
  modport slave  (input req, wr, addr, wdata, output ready, rvalid, rdata, err);
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY cycles,
// then services it against a word-addressed RAM and returns a one-cycle response.
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  state_t          next_state;
  logic [3:0]      counter;
  logic            cap_wr;
  logic            cap_err;
  logic [AW-1:0]   cap_idx;
  logic [31:0]     cap_wdata;
  logic [31:0]     mem [DEPTH];

  logic            accept;
  logic            in_err;
  logic            enter_resp;
  logic            eff_wr;
  logic            eff_err;
  logic [AW-1:0]   eff_idx;
  logic [31:0]     eff_wdata;

  logic            rvalid_q;
  logic            err_q;
  logic [31:0]     rdata_q;

  assign bus.ready = (state == IDLE) && !reset;
  assign accept    = bus.req && bus.ready;
  assign in_err    = (bus.addr[1:0] != 2'b00) || (bus.addr[31:2] >= 30'(DEPTH));

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = (LATENCY == 0) ? RESP : WAIT;
      WAIT: if (counter == 4'd1) next_state = RESP;
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // With LATENCY=0 the RAM is accessed on the acceptance edge itself, so the
  // request fields come straight from the bus instead of the capture registers.
  always_comb begin
    enter_resp = (next_state == RESP) && (state != RESP);
    if (state == IDLE) begin
      eff_wr    = bus.wr;
      eff_err   = in_err;
      eff_idx   = bus.addr[AW+1:2];
      eff_wdata = bus.wdata;
    end else begin
      eff_wr    = cap_wr;
      eff_err   = cap_err;
      eff_idx   = cap_idx;
      eff_wdata = cap_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= 4'd0;
      cap_wr    <= 1'b0;
      cap_err   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= 32'd0;
    end else begin
      state <= next_state;
      if (accept) begin
        counter   <= 4'(LATENCY);
        cap_wr    <= bus.wr;
        cap_err   <= in_err;
        cap_idx   <= bus.addr[AW+1:2];
        cap_wdata <= bus.wdata;
      end else if (state == WAIT) begin
        counter <= counter - 4'd1;
      end
    end
  end

  // RAM contents survive reset; a reset on the entering edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && eff_wr && !eff_err) begin
      mem[eff_idx] <= eff_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      rvalid_q <= enter_resp;
      err_q    <= enter_resp && eff_err;
      rdata_q  <= (enter_resp && !eff_wr && !eff_err) ? mem[eff_idx] : 32'd0;
    end
  end

  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;
  assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 0, 15) checked against
// a word-array memory model and the LATENCY+1 response-timing rule.
module tb_data_mem_responder;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [1:0]  sel = 2'd0;

  logic        ready_m;
  logic        rvalid_m;
  logic        err_m;
  logic [31:0] rdata_m;

  int checks = 0;
  int passes = 0;
  logic [31:0] model [3][DEPTH];

  data_mem_responder_if if0 ();
  data_mem_responder_if if1 ();
  data_mem_responder_if if2 ();

  assign if0.req = req && (sel == 2'd0);
  assign if1.req = req && (sel == 2'd1);
  assign if2.req = req && (sel == 2'd2);
  assign if0.wr = wr;
  assign if1.wr = wr;
  assign if2.wr = wr;
  assign if0.addr = addr;
  assign if1.addr = addr;
  assign if2.addr = addr;
  assign if0.wdata = wdata;
  assign if1.wdata = wdata;
  assign if2.wdata = wdata;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2))  dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0))  dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(15)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

  always #5 clk = ~clk;

  always_comb begin
    ready_m  = if0.ready;
    rvalid_m = if0.rvalid;
    err_m    = if0.err;
    rdata_m  = if0.rdata;
    if (sel == 2'd1) begin
      ready_m  = if1.ready;
      rvalid_m = if1.rvalid;
      err_m    = if1.err;
      rdata_m  = if1.rdata;
    end else if (sel == 2'd2) begin
      ready_m  = if2.ready;
      rvalid_m = if2.rvalid;
      err_m    = if2.err;
      rdata_m  = if2.rdata;
    end
  end

  function automatic int latOf(input logic [1:0] d);
    return (d == 2'd0) ? 2 : ((d == 2'd1) ? 0 : 15);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction; after acceptance the bus fields are scrambled to prove
  // the responder works from its captured copy. holdWait keeps req high during WAIT.
  task automatic applyStimulus(input logic [1:0] d, input logic w, input logic [31:0] a,
                               input logic [31:0] wd, input int holdWait);
    int n;
    int k;
    int idx;
    logic expErr;
    logic [31:0] expData;
    sel = d; wr = w; addr = a; wdata = wd; req = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ready_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_bound", 32'(n < 50), 32'd1);
    expErr  = (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    idx     = int'((a >> 2) & 32'(DEPTH - 1));
    expData = (expErr || w) ? 32'd0 : model[d][idx];
    if (!expErr && w) model[d][idx] = wd;
    @(posedge clk);
    #1;
    addr = a + 32'd4;
    wdata = ~wd;
    req = (holdWait > 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == holdWait) req = 1'b0;
    end while (!rvalid_m && k < 40);
    req = 1'b0;
    checkOutput("resp_latency", 32'(k), 32'(latOf(d) + 1));
    checkOutput("resp_err", 32'(err_m), 32'(expErr));
    checkOutput("resp_rdata", rdata_m, expData);
    @(negedge clk);
    checkOutput("rvalid_one_cycle", 32'(rvalid_m), 32'd0);
    checkOutput("ready_after_resp", 32'(ready_m), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] prior;
    logic [31:0] q [$];
    int r;
    int acc;
    int resp;
    int seen;
    logic accepted;

    // Reset behaviour
    @(negedge clk);
    checkOutput("reset_ready", 32'(ready_m), 32'd0);
    checkOutput("reset_rvalid", 32'(rvalid_m), 32'd0);
    checkOutput("reset_rdata", rdata_m, 32'd0);
    checkOutput("reset_err", 32'(err_m), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", 32'(ready_m), 32'd1);

    applyStimulus(2'd0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
    applyStimulus(2'd0, 1'b0, 32'h10, 32'd0, 0);

    for (int i = 0; i < DEPTH; i++) applyStimulus(2'd0, 1'b1, 32'(i) << 2, $urandom, 0);

    applyStimulus(2'd0, 1'b0, 32'h13, 32'd0, 0);
    applyStimulus(2'd0, 1'b1, 32'h100, 32'hCAFEF00D, 0);
    applyStimulus(2'd0, 1'b0, 32'h0, 32'd0, 0);

    // Reset during WAIT of a store aborts it
    prior = model[0][2];
    sel = 2'd0; wr = 1'b1; addr = 32'h8; wdata = 32'h12345678; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("ready_in_reset", 32'(ready_m), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    seen = 0;
    @(negedge clk);
    checkOutput("ready_after_abort", 32'(ready_m), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (rvalid_m) seen++;
      @(negedge clk);
    end
    checkOutput("abort_no_rvalid", 32'(seen), 32'd0);
    applyStimulus(2'd0, 1'b0, 32'h8, 32'd0, 0);
    checkOutput("abort_prior_model", model[0][2], prior);

    applyStimulus(2'd0, 1'b1, 32'h20, $urandom, 0);
    applyStimulus(2'd0, 1'b0, 32'h24, 32'd0, 0);
    applyStimulus(2'd0, 1'b0, 32'h20, 32'd0, 0);

    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (r == 7) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else a = 32'($urandom_range(DEPTH, 4096)) << 2;
      applyStimulus(2'd0, 1'($urandom_range(0, 1)), a, $urandom, 0);
    end

    // LATENCY=0 with req held continuously, alternating word 0 / word 1
    applyStimulus(2'd1, 1'b1, 32'h0, $urandom, 0);
    applyStimulus(2'd1, 1'b1, 32'h4, $urandom, 0);
    sel = 2'd1; wr = 1'b0; addr = 32'h0; req = 1'b1;
    #1;
    acc = 0;
    resp = 0;
    for (int i = 0; i < 20; i++) begin
      if (rvalid_m) begin
        resp++;
        if (q.size() > 0) checkOutput("lat0_rdata", rdata_m, q.pop_front());
      end
      accepted = ready_m;
      if (ready_m) begin
        acc++;
        checkOutput("lat0_accept_phase", 32'(i % 2), 32'd0);
        q.push_back(model[1][int'(addr[2])]);
      end
      @(posedge clk);
      #1;
      if (accepted) addr = addr ^ 32'h4;
      @(negedge clk);
    end
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rvalid_m) resp++;
      @(negedge clk);
    end
    checkOutput("lat0_accepts", 32'(acc), 32'd10);
    checkOutput("lat0_responses", 32'(resp), 32'd10);

    // LATENCY=15, with a competing req held during WAIT
    applyStimulus(2'd2, 1'b1, 32'h40, $urandom, 0);
    applyStimulus(2'd2, 1'b0, 32'h40, 32'd0, 5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
